// File: rtl/bt656_timing_decoder.sv
// BT.656 timing decoder: finds EAV/SAV codes and regenerates H/V/F word-aligned with a 5-cycle delayed copy of the stream.
// Optional XY protection-bit checking is enabled by defining TRS_PROTECTION_CHECK_EN.
module bt656_timing_decoder #(
    parameter int LINE_WORDS = 1716
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] data_in,
    output logic [9:0] data_out,
    output logic       H,
    output logic       V,
    output logic       F,
    output logic [9:0] line_count,
    output logic       locked,
    output logic       trs_error
);

    localparam logic [10:0] GAP_LOCK = 11'(LINE_WORDS);
    localparam logic [10:0] GAP_SAT  = 11'(LINE_WORDS + 1);

    // trs_cnt doubles as the state: it counts down the three words after detection
    typedef enum logic [1:0] {
        TRS_IDLE  = 2'd0,
        TRS_LAST  = 2'd1,
        TRS_MID   = 2'd2,
        TRS_FIRST = 2'd3
    } trs_state_t;

    trs_state_t  trs_cnt;
    trs_state_t  trs_cnt_next;

    logic [9:0]  s0;
    logic [9:0]  s1;
    logic [9:0]  s2;
    logic [9:0]  s3;

    logic        preamble;
    logic        detect;
    logic        eav_detect;
    logic        apply_set;
    logic        apply_pend;
    logic        xy_f;
    logic        xy_v;
    logic        xy_h;
    logic        lat_f;
    logic        lat_v;
    logic        lat_h;
    logic [10:0] gap;

`ifdef TRS_PROTECTION_CHECK_EN
    logic        prot_ok;
    logic        bad_trs;
`endif

    assign preamble   = (s3 == 10'h3FF) && (s2 == 10'h000) && (s1 == 10'h000);
    assign xy_f       = s0[8];
    assign xy_v       = s0[7];
    assign xy_h       = s0[6];
    assign eav_detect = detect && xy_h;

`ifdef TRS_PROTECTION_CHECK_EN
    assign prot_ok = (s0[5:2] == {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trs_cnt <= TRS_IDLE;
        end else begin
            trs_cnt <= trs_cnt_next;
        end
    end

    always_comb begin
        trs_cnt_next = trs_cnt;
        detect       = 1'b0;
        apply_set    = 1'b0;
`ifdef TRS_PROTECTION_CHECK_EN
        bad_trs      = 1'b0;
`endif
        case (trs_cnt)
            TRS_IDLE: begin
                if (preamble) begin
`ifdef TRS_PROTECTION_CHECK_EN
                    if (prot_ok) begin
                        detect       = 1'b1;
                        trs_cnt_next = TRS_FIRST;
                    end else begin
                        bad_trs      = 1'b1;
                    end
`else
                    detect       = 1'b1;
                    trs_cnt_next = TRS_FIRST;
`endif
                end
            end
            TRS_FIRST: trs_cnt_next = TRS_MID;
            TRS_MID:   trs_cnt_next = TRS_LAST;
            TRS_LAST: begin
                trs_cnt_next = TRS_IDLE;
                apply_set    = 1'b1;
            end
            default:   trs_cnt_next = TRS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0       <= 10'h000;
            s1       <= 10'h000;
            s2       <= 10'h000;
            s3       <= 10'h000;
            data_out <= 10'h000;
        end else begin
            s0       <= data_in;
            s1       <= s0;
            s2       <= s1;
            s3       <= s2;
            data_out <= s3;
        end
    end

    // apply_pend delays the flag update by one word so it lands on the word after XY;
    // a detection in the same cycle overrides H so a back-to-back code still shows blanking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            apply_pend <= 1'b0;
            lat_f      <= 1'b0;
            lat_v      <= 1'b1;
            lat_h      <= 1'b1;
            H          <= 1'b1;
            V          <= 1'b1;
            F          <= 1'b0;
        end else begin
            apply_pend <= apply_set;
            if (apply_pend) begin
                H <= lat_h;
                V <= lat_v;
                F <= lat_f;
            end
            if (detect) begin
                H     <= 1'b1;
                lat_f <= xy_f;
                lat_v <= xy_v;
                lat_h <= xy_h;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_count <= 10'd0;
            gap        <= GAP_SAT;
            locked     <= 1'b0;
        end else begin
            if (eav_detect) begin
                line_count <= (xy_f != F) ? 10'd0 : line_count + 10'd1;
                gap        <= 11'd1;
                locked     <= (gap == GAP_LOCK);
            end else begin
                if (gap != GAP_SAT) begin
                    gap <= gap + 11'd1;
                end
                if (gap == GAP_SAT) begin
                    locked <= 1'b0;
                end
            end
        end
    end

`ifdef TRS_PROTECTION_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trs_error <= 1'b0;
        end else begin
            trs_error <= bad_trs;
        end
    end
`else
    assign trs_error = 1'b0;
`endif

endmodule

// File: tb/tb_bt656_timing_decoder.sv
// Directed bench for bt656_timing_decoder: SAV/EAV alignment, line counting, lock, field change, masking and reset.
module tb_bt656_timing_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] data_in;
    logic [9:0] data_out;
    logic       H;
    logic       V;
    logic       F;
    logic [9:0] line_count;
    logic       locked;
    logic       trs_error;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];
    logic [9:0] fp_words [0:9];
    logic       flag_chg;

    always #5 clk = ~clk;

    bt656_timing_decoder #(.LINE_WORDS(1716)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .H          (H),
        .V          (V),
        .F          (F),
        .line_count (line_count),
        .locked     (locked),
        .trs_error  (trs_error)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // data_out is always the word sent five edges earlier; the queue holds the four in flight
    task automatic prime_q();
        exp_q.delete();
        repeat (4) exp_q.push_back(10'h000);
    endtask

    task automatic put(input logic [9:0] w);
        logic [9:0] e;
        data_in = w;
        @(posedge clk);
        #1;
        if (reset_n) begin
            exp_q.push_back(w);
            e = exp_q.pop_front();
            check_val("data_out", 32'(data_out), 32'(e));
        end
    endtask

    task automatic trs(input logic [9:0] xy);
        put(10'h3FF);
        put(10'h000);
        put(10'h000);
        put(xy);
    endtask

    task automatic blank(input int n);
        repeat (n) put(10'h200);
    endtask

    task automatic active(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            put(10'((32'h040 + 32'(start) + 32'(i)) & 32'h3FF));
        end
    endtask

    task automatic rest(input logic [9:0] sav, input int nblank);
        blank(nblank);
        trs(sav);
        active(0, 1440);
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_data_out"},   32'(data_out),   32'h000);
        check_val({pfx, "_h"},          32'(H),          32'd1);
        check_val({pfx, "_v"},          32'(V),          32'd1);
        check_val({pfx, "_f"},          32'(F),          32'd0);
        check_val({pfx, "_line_count"}, 32'(line_count), 32'd0);
        check_val({pfx, "_locked"},     32'(locked),     32'd0);
        check_val({pfx, "_trs_error"},  32'(trs_error),  32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        data_in = 10'h000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset_n = 1'b1;
        prime_q();
        blank(8);

        // SAV F=0 V=0 H=0 followed by the active ramp
        trs(10'h200);
        active(0, 1);
        check_val("sav_out_3ff", 32'(data_out), 32'h3FF);
        check_val("sav_h_3ff",   32'(H),        32'd1);
        check_val("sav_v_hold",  32'(V),        32'd1);
        active(1, 3);
        check_val("sav_h_xy",    32'(H),        32'd1);
        check_val("sav_out_xy",  32'(data_out), 32'h200);
        active(4, 1);
        check_val("sav_h_fall",  32'(H),        32'd0);
        check_val("sav_out_040", 32'(data_out), 32'h040);
        check_val("sav_v",       32'(V),        32'd0);
        check_val("sav_f",       32'(F),        32'd0);
        active(5, 1435);

        // EAV #1: first after reset, never locks
        trs(10'h274);
        put(10'h200);
        check_val("eav1_out", 32'(data_out),   32'h3FF);
        check_val("eav1_h",   32'(H),          32'd1);
        check_val("eav1_lc",  32'(line_count), 32'd1);
        check_val("eav1_lck", 32'(locked),     32'd0);
        blank(4);
        check_val("eav1_h_after", 32'(H), 32'd1);
        check_val("eav1_v_after", 32'(V), 32'd0);
        rest(10'h200, 263);

        trs(10'h274);
        put(10'h200);
        check_val("eav2_lck", 32'(locked),     32'd1);
        check_val("eav2_lc",  32'(line_count), 32'd2);
        rest(10'h200, 267);

        trs(10'h274);
        put(10'h200);
        check_val("eav3_lck", 32'(locked),     32'd1);
        check_val("eav3_lc",  32'(line_count), 32'd3);
        rest(10'h200, 266);

        // previous line was 1715 words
        trs(10'h274);
        put(10'h200);
        check_val("eav4_lck_short", 32'(locked),     32'd0);
        check_val("eav4_lc",        32'(line_count), 32'd4);
        rest(10'h200, 267);

        // field change: EAV F=1 V=1 H=1
        trs(10'h3C4);
        put(10'h200);
        check_val("eav5_lck",  32'(locked),     32'd1);
        check_val("eav5_lc",   32'(line_count), 32'd0);
        check_val("eav5_f_3ff", 32'(F),         32'd0);
        blank(3);
        check_val("eav5_f_xy", 32'(F),          32'd0);
        blank(1);
        check_val("eav5_f",    32'(F),          32'd1);
        check_val("eav5_v",    32'(V),          32'd1);
        check_val("eav5_h",    32'(H),          32'd1);
        rest(10'h3B0, 263);

        trs(10'h3C4);
        put(10'h200);
        check_val("eav6_lc",  32'(line_count), 32'd1);
        check_val("eav6_lck", 32'(locked),     32'd1);
        blank(267);

        // SAV with a bad protection bit
        trs(10'h204);
        active(0, 1);
        check_val("prot_out_3ff", 32'(data_out), 32'h3FF);
`ifdef TRS_PROTECTION_CHECK_EN
        check_val("prot_err_pulse", 32'(trs_error), 32'd1);
`else
        check_val("prot_err_pulse", 32'(trs_error), 32'd0);
`endif
        active(1, 1);
        check_val("prot_err_end", 32'(trs_error), 32'd0);
        active(2, 3);
`ifdef TRS_PROTECTION_CHECK_EN
        check_val("prot_h", 32'(H), 32'd1);
`else
        check_val("prot_h", 32'(H), 32'd0);
`endif
        check_val("prot_lc", 32'(line_count), 32'd1);
        active(5, 1435);

        // more than LINE_WORDS+1 words with no EAV
        blank(300);
        check_val("lock_timeout", 32'(locked), 32'd0);

        // false preambles inside active video
        trs(10'h200);
        active(0, 8);
        check_val("fp_h_pre", 32'(H), 32'd0);
        fp_words = '{10'h3FF, 10'h100, 10'h3FF, 10'h000, 10'h100,
                     10'h050, 10'h3FF, 10'h3FF, 10'h000, 10'h001};
        flag_chg = 1'b0;
        for (int i = 0; i < 10; i++) begin
            put(fp_words[i]);
            if (H !== 1'b0 || V !== 1'b0 || F !== 1'b0) flag_chg = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            active(20 + i, 1);
            if (H !== 1'b0 || V !== 1'b0 || F !== 1'b0) flag_chg = 1'b1;
        end
        check_val("fp_no_flag_change", 32'(flag_chg), 32'd0);

        // reset asserted during the XY word of an EAV
        put(10'h3FF);
        put(10'h000);
        put(10'h000);
        reset_n = 1'b0;
        put(10'h274);
        check_reset_state("rst_xy");
        reset_n = 1'b1;
        prime_q();
        flag_chg = 1'b0;
        for (int i = 0; i < 12; i++) begin
            put(10'h200);
            if (H !== 1'b1 || V !== 1'b1) flag_chg = 1'b1;
        end
        check_val("rst_xy_no_detect", 32'(flag_chg),   32'd0);
        check_val("rst_xy_lc",        32'(line_count), 32'd0);

        // back-to-back EAV then SAV
        trs(10'h274);
        trs(10'h200);
        active(0, 1);
        check_val("b2b_out_3ff", 32'(data_out),   32'h3FF);
        check_val("b2b_h_sav",   32'(H),          32'd1);
        check_val("b2b_lc",      32'(line_count), 32'd1);
        active(1, 3);
        check_val("b2b_h_xy",    32'(H),          32'd1);
        active(4, 1);
        check_val("b2b_h_fall",  32'(H),          32'd0);
        check_val("b2b_out_040", 32'(data_out),   32'h040);
        check_val("b2b_v",       32'(V),          32'd0);
        active(5, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
